axi_stream_extract_header: RTL and testbench

//  Receive-side counterpart of the header inserter. Strips a 1..DATA_BYTE_WIDTH-byte header from the front of

---
 rtl/axi_stream_extract_header.sv | 220 ++++++++++++++++++++++
 tb/tb_axi_stream_extract_header.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_extract_header.sv
// Strips a 1..S byte header from the front of each AXI-Stream packet, emits it on a
// side channel (right-aligned) and re-aligns the remaining payload MSB-first.

module axi_stream_extract_header_lane (
  input  logic [7:0] byte_in,
  input  logic       keep,
  output logic [7:0] byte_out
);
  assign byte_out = keep ? byte_in : 8'h00;
endmodule

module axi_stream_extract_header #(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_BYTE_WIDTH = DATA_WIDTH/8,
  parameter int BYTE_CNT_WIDTH  = $clog2(DATA_BYTE_WIDTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_in,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic [DATA_BYTE_WIDTH-1:0] keep_in,
  input  logic                       last_in,
  output logic                       ready_in,
  output logic                       valid_out,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic [DATA_BYTE_WIDTH-1:0] keep_out,
  output logic                       last_out,
  input  logic                       ready_out,
  input  logic                       valid_extract,
  input  logic [BYTE_CNT_WIDTH-1:0]  byte_extract_cnt,
  output logic                       ready_extract,
  output logic                       valid_header,
  output logic [DATA_WIDTH-1:0]      data_header,
  output logic [DATA_BYTE_WIDTH-1:0] keep_header,
  input  logic                       ready_header,
  output logic                       err_short
);
  localparam int S  = DATA_BYTE_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(S+1);

  typedef enum logic [1:0] {IDLE, FIRST, BODY, FLUSH} state_t;

  function automatic logic [S-1:0] top_mask(input int n);
    logic [S-1:0] ones;
    ones = '1;
    return ~(ones >> n);
  endfunction

  function automatic logic [S-1:0] low_mask(input int n);
    logic [S-1:0] ones;
    ones = '1;
    return ~(ones << n);
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] hlen_q, hlen_d;
  logic [CW-1:0] flush_n_q, flush_n_d;
  logic [DW-1:0] resid_q, resid_d;
  logic          valid_out_q, valid_out_d;
  logic [DW-1:0] data_out_q, data_out_d;
  logic [S-1:0]  keep_out_q, keep_out_d;
  logic          last_out_q, last_out_d;
  logic          valid_header_q, valid_header_d;
  logic [DW-1:0] data_header_q, data_header_d;
  logic [S-1:0]  keep_header_q, keep_header_d;
  logic          err_q, err_d;

  logic [S-1:0][7:0] data_m_b;
  logic [DW-1:0]     data_m;
  logic [DW-1:0]     hdr_part, res_part;
  logic [CW-1:0]     k_in;
  logic              out_free, hdr_free, ready_in_c, ready_extract_c;
  int                p_len, tot_len;

  // Invalid input bytes are zeroed up front so every shifted view is already clean.
  for (genvar i = 0; i < S; i++) begin : g_lane
    axi_stream_extract_header_lane u_lane (
      .byte_in  (data_in[i*8 +: 8]),
      .keep     (keep_in[i]),
      .byte_out (data_m_b[i])
    );
  end
  assign data_m = data_m_b;

  // Top H bytes right-aligned, and the low S-H bytes moved up to the MSB end.
  assign hdr_part = data_m >> ((S - int'(hlen_q)) * 8);
  assign res_part = data_m << (int'(hlen_q) * 8);

  always_comb begin
    k_in = '0;
    for (int i = 0; i < S; i++) k_in = k_in + CW'(keep_in[i]);
  end

  always_comb begin
    state_d         = state_q;
    hlen_d          = hlen_q;
    flush_n_d       = flush_n_q;
    resid_d         = resid_q;
    out_free        = !valid_out_q || ready_out;
    hdr_free        = !valid_header_q || ready_header;
    valid_out_d     = valid_out_q && !ready_out;
    data_out_d      = data_out_q;
    keep_out_d      = keep_out_q;
    last_out_d      = last_out_q;
    valid_header_d  = valid_header_q && !ready_header;
    data_header_d   = data_header_q;
    keep_header_d   = keep_header_q;
    err_d           = 1'b0;
    ready_in_c      = 1'b0;
    ready_extract_c = 1'b0;
    p_len           = int'(k_in) - int'(hlen_q);
    tot_len         = S - int'(hlen_q) + int'(k_in);
    unique case (state_q)
      IDLE: begin
        ready_extract_c = 1'b1;
        if (valid_extract) begin
          hlen_d  = CW'(byte_extract_cnt) + CW'(1);
          state_d = FIRST;
        end
      end
      FIRST: begin
        ready_in_c = out_free && hdr_free;
        if (valid_in && ready_in_c) begin
          valid_header_d = 1'b1;
          data_header_d  = hdr_part;
          keep_header_d  = low_mask(int'(hlen_q));
          resid_d        = res_part;
          if (last_in) begin
            state_d = IDLE;
            if (p_len > 0) begin
              valid_out_d = 1'b1;
              data_out_d  = res_part;
              keep_out_d  = top_mask(p_len);
              last_out_d  = 1'b1;
            end else if (p_len < 0) begin
              err_d = 1'b1;
            end
          end else begin
            state_d = BODY;
          end
        end
      end
      BODY: begin
        ready_in_c = out_free;
        if (valid_in && ready_in_c) begin
          valid_out_d = 1'b1;
          data_out_d  = resid_q | hdr_part;
          resid_d     = res_part;
          keep_out_d  = '1;
          last_out_d  = 1'b0;
          if (last_in) begin
            if (tot_len <= S) begin
              keep_out_d = top_mask(tot_len);
              last_out_d = 1'b1;
              state_d    = IDLE;
            end else begin
              // Tail spills past one beat: the leftover k-H bytes go out next.
              flush_n_d = CW'(p_len);
              state_d   = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        if (out_free) begin
          valid_out_d = 1'b1;
          data_out_d  = resid_q;
          keep_out_d  = top_mask(int'(flush_n_q));
          last_out_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      hlen_q         <= '0;
      flush_n_q      <= '0;
      resid_q        <= '0;
      valid_out_q    <= 1'b0;
      data_out_q     <= '0;
      keep_out_q     <= '0;
      last_out_q     <= 1'b0;
      valid_header_q <= 1'b0;
      data_header_q  <= '0;
      keep_header_q  <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      hlen_q         <= hlen_d;
      flush_n_q      <= flush_n_d;
      resid_q        <= resid_d;
      valid_out_q    <= valid_out_d;
      data_out_q     <= data_out_d;
      keep_out_q     <= keep_out_d;
      last_out_q     <= last_out_d;
      valid_header_q <= valid_header_d;
      data_header_q  <= data_header_d;
      keep_header_q  <= keep_header_d;
      err_q          <= err_d;
    end
  end

  // Gated so every output, including the IDLE-state ready, reads 0 while in reset.
  assign ready_extract = ready_extract_c && rst_n;
  assign ready_in      = ready_in_c;
  assign valid_out     = valid_out_q;
  assign data_out      = data_out_q;
  assign keep_out      = keep_out_q;
  assign last_out      = last_out_q;
  assign valid_header  = valid_header_q;
  assign data_header   = data_header_q;
  assign keep_header   = keep_header_q;
  assign err_short     = err_q;

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// Scoreboard bench for axi_stream_extract_header: directed packets, random packets with
// back-pressure, and a mid-packet reset.

module tb_axi_stream_extract_header;
  typedef struct packed { logic [31:0] data; logic [3:0] keep; logic last; } beat_t;
  typedef struct packed { logic [31:0] data; logic [3:0] keep; } hdr_t;

  logic        clk, rst_n;
  logic        valid_in, last_in, ready_in;
  logic [31:0] data_in;
  logic [3:0]  keep_in;
  logic        valid_out, last_out, ready_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        valid_extract, ready_extract;
  logic [1:0]  byte_extract_cnt;
  logic        valid_header, ready_header, err_short;
  logic [31:0] data_header;
  logic [3:0]  keep_header;

  beat_t drv_q[$];
  beat_t exp_q[$];
  hdr_t  hexp_q[$];
  int    n_tests = 0, n_fail = 0, err_seen = 0;
  int    out_pct = 100, hdr_pct = 100;
  bit    mon_en = 0;
  bit    pend_o = 0, pend_h = 0, err_prev = 0;
  beat_t hold_o;
  hdr_t  hold_h;

  axi_stream_extract_header dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in), .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out), .ready_out(ready_out),
    .valid_extract(valid_extract), .byte_extract_cnt(byte_extract_cnt), .ready_extract(ready_extract),
    .valid_header(valid_header), .data_header(data_header), .keep_header(keep_header),
    .ready_header(ready_header), .err_short(err_short)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always begin
    @(negedge clk);
    ready_out    = ($urandom_range(0, 99) < out_pct);
    ready_header = ($urandom_range(0, 99) < hdr_pct);
  end

  // Monitor: pops expectations on each handshake, checks hold-while-stalled and err pulse width.
  always begin
    beat_t e;
    hdr_t  eh;
    @(negedge clk);
    #2;
    if (!mon_en) begin
      pend_o = 0; pend_h = 0; err_prev = 0;
    end else begin
      if (pend_o) begin
        n_tests++;
        if (valid_out !== 1'b1 || data_out !== hold_o.data || keep_out !== hold_o.keep || last_out !== hold_o.last) begin
          n_fail++;
          $display("FAIL out_stable got v=%0b %h/%b/%0b want v=1 %h/%b/%0b", valid_out, data_out, keep_out, last_out, hold_o.data, hold_o.keep, hold_o.last);
        end
      end
      if (pend_h) begin
        n_tests++;
        if (valid_header !== 1'b1 || data_header !== hold_h.data || keep_header !== hold_h.keep) begin
          n_fail++;
          $display("FAIL hdr_stable got v=%0b %h/%b want v=1 %h/%b", valid_header, data_header, keep_header, hold_h.data, hold_h.keep);
        end
      end
      if (valid_out && ready_out) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL payload_extra got %h/%b/%0b want no beat", data_out, keep_out, last_out);
        end else begin
          e = exp_q.pop_front();
          if (data_out !== e.data || keep_out !== e.keep || last_out !== e.last) begin
            n_fail++;
            $display("FAIL payload got %h/%b/%0b want %h/%b/%0b", data_out, keep_out, last_out, e.data, e.keep, e.last);
          end
        end
      end
      if (valid_header && ready_header) begin
        n_tests++;
        if (hexp_q.size() == 0) begin
          n_fail++;
          $display("FAIL header_extra got %h/%b want no header", data_header, keep_header);
        end else begin
          eh = hexp_q.pop_front();
          if (data_header !== eh.data || keep_header !== eh.keep) begin
            n_fail++;
            $display("FAIL header got %h/%b want %h/%b", data_header, keep_header, eh.data, eh.keep);
          end
        end
      end
      pend_o = valid_out && !ready_out;
      hold_o.data = data_out; hold_o.keep = keep_out; hold_o.last = last_out;
      pend_h = valid_header && !ready_header;
      hold_h.data = data_header; hold_h.keep = keep_header;
      if (err_short === 1'b1) begin
        err_seen++;
        if (err_prev) begin
          n_tests++; n_fail++;
          $display("FAIL err_width got 2+ cycles want 1");
        end
      end
      err_prev = (err_short === 1'b1);
    end
  end

  task automatic add_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    beat_t b;
    b.data = d; b.keep = k; b.last = l;
    drv_q.push_back(b);
  endtask

  task automatic exp_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    beat_t b;
    b.data = d; b.keep = k; b.last = l;
    exp_q.push_back(b);
  endtask

  task automatic exp_hdr(input logic [31:0] d, input logic [3:0] k);
    hdr_t h;
    h.data = d; h.keep = k;
    hexp_q.push_back(h);
  endtask

  task automatic drive_packet(input int h, input int gap_pct);
    int guard;
    @(negedge clk);
    valid_extract = 1'b1;
    byte_extract_cnt = 2'(h - 1);
    #1;
    guard = 0;
    while (!ready_extract && guard < 500) begin @(negedge clk); #1; guard++; end
    if (guard >= 500) begin
      n_tests++; n_fail++;
      $display("FAIL extract_timeout ready_extract=%0b want 1", ready_extract);
    end
    while (drv_q.size() > 0) begin
      @(negedge clk);
      valid_extract = 1'b0;
      if ($urandom_range(0, 99) < gap_pct) begin
        valid_in = 1'b0;
        continue;
      end
      valid_in = 1'b1;
      data_in  = drv_q[0].data;
      keep_in  = drv_q[0].keep;
      last_in  = drv_q[0].last;
      #1;
      guard = 0;
      while (!ready_in && guard < 500) begin @(negedge clk); #1; guard++; end
      if (guard >= 500) begin
        n_tests++; n_fail++;
        $display("FAIL ready_in_timeout ready_in=%0b want 1", ready_in);
        drv_q.delete();
      end else begin
        void'(drv_q.pop_front());
      end
    end
    @(negedge clk);
    valid_extract = 1'b0;
    valid_in = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int guard;
    guard = 0;
    while ((exp_q.size() > 0 || hexp_q.size() > 0 || valid_out || valid_header) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0 || hexp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain got %0d payload/%0d header pending want 0/0", tag, exp_q.size(), hexp_q.size());
    end
  endtask

  task automatic check_err(input string tag, input int e0, input int want);
    n_tests++;
    if (err_seen - e0 !== want) begin
      n_fail++;
      $display("FAIL %s_err got %0d pulses want %0d", tag, err_seen - e0, want);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({valid_out, valid_header, err_short, ready_in, ready_extract, last_out} !== 6'b0 ||
        data_out !== 32'h0 || keep_out !== 4'h0 || data_header !== 32'h0 || keep_header !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got vo=%0b vh=%0b err=%0b ri=%0b re=%0b do=%h ko=%b dh=%h kh=%b want all 0",
               valid_out, valid_header, err_short, ready_in, ready_extract, data_out, keep_out, data_header, keep_header);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (ready_extract !== 1'b1 || ready_in !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ready got re=%0b ri=%0b want re=1 ri=0", ready_extract, ready_in);
    end
    mon_en = 1;
  endtask

  task automatic test_h2_multi;
    int e0;
    e0 = err_seen;
    add_beat(32'hAABBCCDD, 4'hF, 0);
    add_beat(32'h11223344, 4'hF, 0);
    add_beat(32'h55667788, 4'hF, 1);
    exp_hdr(32'h0000AABB, 4'b0011);
    exp_beat(32'hCCDD1122, 4'hF, 0);
    exp_beat(32'h33445566, 4'hF, 0);
    exp_beat(32'h77880000, 4'b1100, 1);
    drive_packet(2, 0);
    wait_drain("h2_multi");
    check_err("h2_multi", e0, 0);
  endtask

  task automatic test_h4_full;
    int e0;
    e0 = err_seen;
    add_beat(32'hDEADBEEF, 4'hF, 0);
    add_beat(32'h12345678, 4'b1110, 1);
    exp_hdr(32'hDEADBEEF, 4'hF);
    exp_beat(32'h12345600, 4'b1110, 1);
    drive_packet(4, 0);
    wait_drain("h4_full");
    check_err("h4_full", e0, 0);
  endtask

  task automatic test_h3_tail;
    int e0;
    e0 = err_seen;
    add_beat(32'hA1A2A3A4, 4'hF, 0);
    add_beat(32'hB1EEEEEE, 4'b1000, 1);
    exp_hdr(32'h00A1A2A3, 4'b0111);
    exp_beat(32'hA4B10000, 4'b1100, 1);
    drive_packet(3, 0);
    wait_drain("h3_tail");
    check_err("h3_tail", e0, 0);
  endtask

  task automatic test_hdr_only;
    int e0;
    e0 = err_seen;
    add_beat(32'h9A9B5555, 4'b1100, 1);
    exp_hdr(32'h00009A9B, 4'b0011);
    drive_packet(2, 0);
    wait_drain("hdr_only");
    check_err("hdr_only", e0, 0);
  endtask

  task automatic test_short;
    int e0;
    e0 = err_seen;
    add_beat(32'hC1C2DEAD, 4'b1100, 1);
    exp_hdr(32'hC1C20000, 4'hF);
    drive_packet(4, 0);
    wait_drain("short");
    check_err("short", e0, 1);
  endtask

  task automatic test_random;
    int e0, exp_err;
    e0 = err_seen;
    exp_err = 0;
    out_pct = 70;
    hdr_pct = 60;
    for (int p = 0; p < 1000; p++) begin
      int h, len, nb, m, cnt;
      logic [7:0] pb[$];
      logic [31:0] d;
      logic [3:0] kp;
      hdr_t hx;
      beat_t bx;
      h = $urandom_range(1, 4);
      len = $urandom_range(1, 14);
      pb.delete();
      for (int i = 0; i < len; i++) pb.push_back(8'($urandom));
      nb = (len + 3) / 4;
      for (int b = 0; b < nb; b++) begin
        d = $urandom;
        kp = 4'h0;
        m = (b == nb - 1) ? len - 4 * b : 4;
        for (int j = 0; j < m; j++) begin
          d[(3 - j) * 8 +: 8] = pb[4 * b + j];
          kp[3 - j] = 1'b1;
        end
        add_beat(d, kp, b == nb - 1);
      end
      hx = '0;
      for (int j = 0; j < h; j++) begin
        if (j < len) hx.data[(h - 1 - j) * 8 +: 8] = pb[j];
        hx.keep[j] = 1'b1;
      end
      hexp_q.push_back(hx);
      if (len < h) exp_err++;
      cnt = 0;
      bx = '0;
      for (int i = h; i < len; i++) begin
        bx.data[(3 - cnt) * 8 +: 8] = pb[i];
        bx.keep[3 - cnt] = 1'b1;
        cnt++;
        if (cnt == 4 || i == len - 1) begin
          bx.last = (i == len - 1);
          exp_q.push_back(bx);
          bx = '0;
          cnt = 0;
        end
      end
      drive_packet(h, 30);
    end
    wait_drain("random");
    check_err("random", e0, exp_err);
    out_pct = 100;
    hdr_pct = 100;
  endtask

  task automatic test_mid_reset;
    mon_en = 0;
    out_pct = 0;
    hdr_pct = 0;
    repeat (2) @(negedge clk);
    add_beat(32'h01020304, 4'hF, 0);
    add_beat(32'h05060708, 4'hF, 0);
    drive_packet(2, 0);
    n_tests++;
    if (valid_out !== 1'b1 || valid_header !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre got vo=%0b vh=%0b want 1/1", valid_out, valid_header);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (valid_out !== 1'b0 || valid_header !== 1'b0 || err_short !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_async got vo=%0b vh=%0b err=%0b want 0/0/0", valid_out, valid_header, err_short);
    end
    exp_q.delete();
    hexp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_pct = 100;
    hdr_pct = 100;
    repeat (2) @(negedge clk);
    mon_en = 1;
    test_h2_multi();
  endtask

  initial begin
    rst_n = 1'b0;
    valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    valid_extract = 1'b0; byte_extract_cnt = '0;
    ready_out = 1'b0; ready_header = 1'b0;
    test_reset();
    test_h2_multi();
    test_h4_full();
    test_h3_tail();
    test_hdr_only();
    test_short();
    test_random();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
